// File: rtl/crc_frame_ctrl.sv
// Front-end controller for a serial CRC-8 core: serializes stream bytes LSB-first
// into the core, then gathers the core's serial CRC into a parallel, checked result.
module crc_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CRC_WIDTH  = 8,
   parameter int TIMEOUT    = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic [CRC_WIDTH-1:0]  exp_crc,
   output logic                  crc_init,
   output logic                  crc_active,
   output logic                  crc_data,
   input  logic                  crc_valid,
   input  logic                  crc_bit,
   output logic                  out_valid,
   output logic [CRC_WIDTH-1:0]  crc_out,
   output logic                  crc_match,
   output logic                  err_underrun,
   output logic                  err_timeout,
   output logic                  err_drop
);

   localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int CW  = $clog2(CRC_WIDTH + 1);
   localparam int CIW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);

   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CAP_LAST = CW'(CRC_WIDTH - 1);
   localparam logic [TW-1:0] TIM_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_SHIFT, S_WAIT_VALID, S_CAPTURE, S_DONE
   } state_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  word;
   logic                   last;
   logic [CRC_WIDTH-1:0]   exp_q;
   logic [BW-1:0]          bit_cnt;
   logic [BW-1:0]          bit_nxt;
   logic [CW-1:0]          cap_cnt;
   logic [TW-1:0]          timer;
   logic [CRC_WIDTH-1:0]   cap;
   logic [CRC_WIDTH-1:0]   cap_upd;

   assign bit_nxt = bit_cnt + 1'b1;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cap_upd = cap;
      cap_upd[cap_cnt[CIW-1:0]] = crc_bit;
   end

   // NOTE: state uses non-blocking assignments so every branch sees the pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         word         <= '0;
         last         <= 1'b0;
         exp_q        <= '0;
         bit_cnt      <= '0;
         cap_cnt      <= '0;
         timer        <= '0;
         cap          <= '0;
         in_ready     <= 1'b0;
         crc_init     <= 1'b0;
         crc_active   <= 1'b0;
         crc_data     <= 1'b0;
         out_valid    <= 1'b0;
         crc_out      <= '0;
         crc_match    <= 1'b0;
         err_underrun <= 1'b0;
         err_timeout  <= 1'b0;
         err_drop     <= 1'b0;
      end else begin
         crc_init  <= 1'b0;
         out_valid <= 1'b0;
         crc_match <= 1'b0;
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  word     <= in_data;
                  last     <= in_last;
                  if (in_last) exp_q <= exp_crc;
                  cap      <= '0;
                  in_ready <= 1'b0;
                  crc_init <= 1'b1;
                  state    <= S_INIT;
               end
            end
            S_INIT: begin
               bit_cnt    <= '0;
               crc_active <= 1'b1;
               crc_data   <= word[0];
               state      <= S_SHIFT;
            end
            S_SHIFT: begin
               if (bit_cnt != BIT_LAST) begin
                  bit_cnt  <= bit_nxt;
                  crc_data <= word[bit_nxt];
                  // Ready is offered only on the final bit of a non-last word.
                  in_ready <= (bit_nxt == BIT_LAST) && !last;
               end else if (!last) begin
                  in_ready <= 1'b0;
                  if (in_valid) begin
                     word     <= in_data;
                     last     <= in_last;
                     if (in_last) exp_q <= exp_crc;
                     bit_cnt  <= '0;
                     crc_data <= in_data[0];
                  end else begin
                     err_underrun <= 1'b1;
                     crc_active   <= 1'b0;
                     crc_data     <= 1'b0;
                     crc_out      <= cap;
                     out_valid    <= 1'b1;
                     state        <= S_DONE;
                  end
               end else begin
                  crc_active <= 1'b0;
                  crc_data   <= 1'b0;
                  timer      <= '0;
                  cap_cnt    <= '0;
                  state      <= S_WAIT_VALID;
               end
            end
            S_WAIT_VALID: begin
               if (crc_valid) begin
                  cap     <= cap_upd;
                  cap_cnt <= CW'(1);
                  state   <= S_CAPTURE;
               end else if (timer == TIM_LAST) begin
                  err_timeout <= 1'b1;
                  crc_out     <= cap;
                  out_valid   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_CAPTURE: begin
               if (crc_valid) begin
                  cap     <= cap_upd;
                  cap_cnt <= cap_cnt + 1'b1;
                  if (cap_cnt == CAP_LAST) begin
                     crc_out   <= cap_upd;
                     crc_match <= (cap_upd == exp_q);
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end else begin
                  err_drop  <= 1'b1;
                  crc_out   <= cap;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               err_underrun <= 1'b0;
               err_timeout  <= 1'b0;
               err_drop     <= 1'b0;
               in_ready     <= 1'b1;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
